// File: rtl/pipe_pkg.sv
// Shared pipeline types: control-bundle layout, ID/EX FSM states and the EX slot record.
package pipe_pkg;
  localparam int CTRL_W         = 8;
  localparam int CTRL_MEM_READ  = 0;
  localparam int CTRL_REG_WRITE = 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HOLD   = 2'd2
  } idex_state_e;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [31:0]       op1;
    logic [31:0]       op2;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } ex_slot_t;

  // x0 always reads as zero, whatever the register file returns
  function automatic logic [31:0] x0_mask(input logic [4:0] idx, input logic [31:0] d);
    return (idx == 5'd0) ? 32'd0 : d;
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side fields, register-file data, EX control, writeback and EX outputs.
interface id_ex_stage_if #(parameter int CNT_W = 16);
  import pipe_pkg::*;

  logic              id_valid;
  logic [31:0]       id_pc;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       rf_data1;
  logic [31:0]       rf_data2;
  logic              ex_stall;
  logic              flush;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              stall_id;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_imm;
  logic [31:0]       ex_op1;
  logic [31:0]       ex_op2;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_ctrl,
           rf_data1, rf_data2, ex_stall, flush, wb_we, wb_rd, wb_data,
    input  stall_id, ex_valid, ex_pc, ex_imm, ex_op1, ex_op2,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl, bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_ctrl,
           rf_data1, rf_data2, ex_stall, flush, wb_we, wb_rd, wb_data,
    output stall_id, ex_valid, ex_pc, ex_imm, ex_op1, ex_op2,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl, bubble_cnt
  );
endinterface

// File: rtl/id_ex_hazard.sv
// Combinational load-use hazard and ID stall decode for the ID/EX stage.
module id_ex_hazard (
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_stall,
  input  logic       flush,
  output logic       lu_haz,
  output logic       stall_id
);
  assign lu_haz = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // flush kills the transfer, so ID must be free to refetch the target
  assign stall_id = rst & ~flush & (ex_stall | lu_haz);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX back-pressure and flush.
// Build option: define IDEX_WB_BYPASS_EN to forward same-cycle writeback data into ex_op1/ex_op2.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);
  ex_slot_t         ex_q;
  logic [CNT_W-1:0] cnt_q;
  idex_state_e      state_q, state_d;
  logic             lu_haz;
  logic [31:0]      op1_src, op2_src;

  id_ex_hazard u_haz (
    .rst        (rst),
    .id_valid   (bus.id_valid),
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .ex_valid   (ex_q.valid),
    .ex_mem_read(ex_q.ctrl[CTRL_MEM_READ]),
    .ex_rd      (ex_q.rd),
    .ex_stall   (bus.ex_stall),
    .flush      (bus.flush),
    .lu_haz     (lu_haz),
    .stall_id   (bus.stall_id)
  );

`ifdef IDEX_WB_BYPASS_EN
  // covers the register-file write/read same-cycle window
  always_comb begin
    op1_src = bus.rf_data1;
    op2_src = bus.rf_data2;
    if (bus.wb_we && bus.wb_rd != 5'd0 && bus.wb_rd == bus.id_rs1) op1_src = bus.wb_data;
    if (bus.wb_we && bus.wb_rd != 5'd0 && bus.wb_rd == bus.id_rs2) op2_src = bus.wb_data;
  end
`else
  logic unused_wb;
  assign op1_src   = bus.rf_data1;
  assign op2_src   = bus.rf_data2;
  assign unused_wb = ^{bus.wb_we, bus.wb_rd, bus.wb_data};
`endif

  always_comb begin
    state_d = ST_RUN;
    if (!rst || bus.flush) state_d = ST_RUN;
    else if (bus.ex_stall) state_d = ST_HOLD;
    else if (lu_haz)       state_d = ST_BUBBLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // state is for debug observation only; the datapath follows state_d
  logic unused_state;
  assign unused_state = ^state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else if (bus.flush) begin
      ex_q.valid <= 1'b0;
      ex_q.ctrl  <= '0;
    end else begin
      case (state_d)
        ST_HOLD: ;
        ST_BUBBLE: begin
          ex_q.valid <= 1'b0;
          ex_q.ctrl  <= '0;
          if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          ex_q.valid <= bus.id_valid;
          ex_q.ctrl  <= bus.id_valid ? bus.id_ctrl : '0;
          ex_q.pc    <= bus.id_pc;
          ex_q.imm   <= bus.id_imm;
          ex_q.rs1   <= bus.id_rs1;
          ex_q.rs2   <= bus.id_rs2;
          ex_q.rd    <= bus.id_rd;
          ex_q.op1   <= x0_mask(bus.id_rs1, op1_src);
          ex_q.op2   <= x0_mask(bus.id_rs2, op2_src);
        end
      endcase
    end
  end

  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_pc      = ex_q.pc;
  assign bus.ex_imm     = ex_q.imm;
  assign bus.ex_op1     = ex_q.op1;
  assign bus.ex_op2     = ex_q.op2;
  assign bus.ex_rs1     = ex_q.rs1;
  assign bus.ex_rs2     = ex_q.rs2;
  assign bus.ex_rd      = ex_q.rd;
  assign bus.ex_ctrl    = ex_q.ctrl;
  assign bus.bubble_cnt = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a stimulus driver with a slot-level reference model, decoupled monitors.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int CNT_W = 4;
`ifdef IDEX_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.CNT_W(CNT_W)) bus ();
  id_ex_stage #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit          r, iv, st, fl, we;
    logic [31:0] pc, imm, d1, d2, wd;
    logic [4:0]  s1, s2, rd, wrd;
    logic [7:0]  ctrl;
  } stim_t;

  typedef struct {
    bit               valid;
    logic [31:0]      pc, imm, op1, op2;
    logic [4:0]       rs1, rs2, rd;
    logic [7:0]       ctrl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t  m;
  exp_t  exp_q[$];
  bit    stall_q[$];
  exp_t  e;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  // EX slot contents become visible just after the edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, e.valid});
      chk("ex_pc", bus.ex_pc, e.pc);
      chk("ex_imm", bus.ex_imm, e.imm);
      chk("ex_op1", bus.ex_op1, e.op1);
      chk("ex_op2", bus.ex_op2, e.op2);
      chk("ex_rs1", {27'd0, bus.ex_rs1}, {27'd0, e.rs1});
      chk("ex_rs2", {27'd0, bus.ex_rs2}, {27'd0, e.rs2});
      chk("ex_rd", {27'd0, bus.ex_rd}, {27'd0, e.rd});
      chk("ex_ctrl", {24'd0, bus.ex_ctrl}, {24'd0, e.ctrl});
      chk("bubble_cnt", {{(32-CNT_W){1'b0}}, bus.bubble_cnt}, {{(32-CNT_W){1'b0}}, e.cnt});
    end
  end

  // stall_id is combinational on the inputs applied at the falling edge
  always @(negedge clk) begin
    #1;
    if (stall_q.size() > 0) chk("stall_id", {31'd0, bus.stall_id}, {31'd0, stall_q.pop_front()});
  end

  task automatic step(input stim_t s);
    bit haz;
    @(negedge clk);
    rst = s.r;
    bus.id_valid = s.iv;  bus.id_pc = s.pc;    bus.id_imm = s.imm;
    bus.id_rs1 = s.s1;    bus.id_rs2 = s.s2;   bus.id_rd = s.rd;
    bus.id_ctrl = s.ctrl; bus.rf_data1 = s.d1; bus.rf_data2 = s.d2;
    bus.ex_stall = s.st;  bus.flush = s.fl;
    bus.wb_we = s.we;     bus.wb_rd = s.wrd;   bus.wb_data = s.wd;

    // a load sitting in EX whose result the ID instruction reads
    haz = s.iv && m.valid && m.ctrl[0] && m.rd != 0 && (m.rd == s.s1 || m.rd == s.s2);
    stall_q.push_back(s.r && !s.fl && (s.st || haz));
    if (!s.r) begin
      m = '{default: '0};
    end else if (s.fl) begin
      m.valid = 0; m.ctrl = 0;
    end else if (s.st) begin
    end else if (haz) begin
      m.valid = 0; m.ctrl = 0;
      if (m.cnt != {CNT_W{1'b1}}) m.cnt = m.cnt + 1;
    end else begin
      m.valid = s.iv; m.ctrl = s.iv ? s.ctrl : 8'd0;
      m.pc = s.pc; m.imm = s.imm; m.rs1 = s.s1; m.rs2 = s.s2; m.rd = s.rd;
      m.op1 = (s.s1 == 0) ? 32'd0 : (BYP && s.we && s.wrd != 0 && s.wrd == s.s1) ? s.wd : s.d1;
      m.op2 = (s.s2 == 0) ? 32'd0 : (BYP && s.we && s.wrd != 0 && s.wrd == s.s2) ? s.wd : s.d2;
    end
    exp_q.push_back(m);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.r = 1'b1;
    return s;
  endfunction

  function automatic stim_t rnd(input int p_rst);
    stim_t s;
    s.r = ($urandom_range(99) >= p_rst);
    s.iv = ($urandom_range(9) != 0);
    s.st = ($urandom_range(4) == 0);
    s.fl = ($urandom_range(9) == 0);
    s.we = $urandom_range(1);
    s.pc = $urandom; s.imm = $urandom; s.d1 = $urandom; s.d2 = $urandom; s.wd = $urandom;
    s.s1 = 5'($urandom_range(7)); s.s2 = 5'($urandom_range(7));
    s.rd = 5'($urandom_range(7)); s.wrd = 5'($urandom_range(7));
    s.ctrl = 8'($urandom);
    return s;
  endfunction

  initial begin
    stim_t s;
    m = '{default: '0};
    rst = 1'b0;
    s = idle();
    step(s);

    // reset with a live instruction presented
    s = rnd(0); s.r = 0; s.iv = 1; step(s); step(s);

    // plain transfer
    s = idle(); s.iv = 1; s.pc = 32'h100; s.s1 = 5; s.d1 = 32'hAA; s.s2 = 6; s.d2 = 32'hBB; s.rd = 9;
    step(s);

    // load x7 in EX, then a consumer of x7 on rs2, then the held consumer moves on
    s = idle(); s.iv = 1; s.pc = 32'h104; s.rd = 7; s.ctrl = 8'h03; step(s);
    s = idle(); s.iv = 1; s.pc = 32'h108; s.s1 = 2; s.s2 = 7; s.d1 = 1; s.d2 = 2; s.rd = 8; s.ctrl = 8'h02;
    step(s); step(s);

    // flush wins over stall, then a 3-cycle stall
    s = idle(); s.iv = 1; s.pc = 32'h10C; s.fl = 1; s.st = 1; step(s);
    s = idle(); s.iv = 1; s.pc = 32'h200; s.s1 = 4; s.d1 = 32'h44; s.rd = 5; s.ctrl = 8'h02; step(s);
    s = idle(); s.iv = 1; s.pc = 32'h204; s.st = 1; s.s1 = 3; s.d1 = 32'h99;
    repeat (3) step(s);

    // writeback forwarding and x0
    s = idle(); s.iv = 1; s.pc = 32'h300; s.s1 = 3; s.d1 = 32'h11; s.we = 1; s.wrd = 3; s.wd = 32'h55;
    step(s);
    s.s1 = 0; s.s2 = 3; s.d2 = 32'h22; step(s);

    // drive the bubble counter past saturation
    for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
      s = idle(); s.iv = 1; s.rd = 7; s.ctrl = 8'h01; step(s);
      s = idle(); s.iv = 1; s.s1 = 7; s.rd = 1; step(s);
    end
    s = idle(); step(s);
    @(posedge clk); #2;
    chk("bubble_sat", {{(32-CNT_W){1'b0}}, bus.bubble_cnt}, {{(32-CNT_W){1'b0}}, {CNT_W{1'b1}}});

    for (int i = 0; i < 2000; i++) step(rnd(2));

    s = idle(); step(s);
    repeat (3) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
